// File: rtl/aud_reg_tone_slave.sv
// rtl/aud_reg_tone_slave.sv - write-only AXI-lite register slave driving a PWM-gated square-wave tone
// AW and W are held independently and committed together; registers feed the tone, PWM and duration timer.
module aud_reg_tone_slave #(
  parameter int TICK_DIV = 1000,
  parameter int PWM_BITS = 7
) (
  input  logic                clk,
  input  logic                ARESETn,
  input  logic [3:0]          AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [PWM_BITS-1:0] WDATA,
  input  logic                WVALID,
  output logic                WREADY,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [1:0]          BRESP,
  output logic                aud_sig
);

  localparam int PER_W = 2 * PWM_BITS;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic                r_aw_held;
  logic                r_w_held;
  logic [3:0]          r_awaddr;
  logic [PWM_BITS-1:0] r_wdata;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_en;
  logic                r_mute;
  logic [PWM_BITS-1:0] r_per_lo;
  logic [PWM_BITS-1:0] r_per_hi;
  logic [PWM_BITS-1:0] r_vol;
  logic [PWM_BITS-1:0] r_remaining;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [PER_W-1:0]    r_tone_cnt;
  logic                r_sq;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_aud_sig;

  logic                w_aw_beat;
  logic                w_w_beat;
  logic                w_commit;
  logic                w_mapped;
  logic                w_wr_ctrl;
  logic                w_wr_per_lo;
  logic                w_wr_per_hi;
  logic                w_wr_vol;
  logic                w_wr_dur;
  logic [PER_W-1:0]    w_period;
  logic                w_tone_run;
  logic                w_tone_wrap;
  logic                w_pwm_on;
  logic                w_timer_run;
  logic                w_tick;
  logic                w_expire;

  assign AWREADY = !r_aw_held && !r_bvalid;
  assign WREADY  = !r_w_held && !r_bvalid;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign aud_sig = r_aud_sig;

  assign w_aw_beat   = AWVALID && AWREADY;
  assign w_w_beat    = WVALID && WREADY;
  assign w_commit    = r_aw_held && r_w_held;
  assign w_mapped    = (r_awaddr <= 4'd4);
  assign w_wr_ctrl   = w_commit && (r_awaddr == 4'd0);
  assign w_wr_per_lo = w_commit && (r_awaddr == 4'd1);
  assign w_wr_per_hi = w_commit && (r_awaddr == 4'd2);
  assign w_wr_vol    = w_commit && (r_awaddr == 4'd3);
  assign w_wr_dur    = w_commit && (r_awaddr == 4'd4);

  assign w_period    = {r_per_hi, r_per_lo};
  assign w_tone_run  = r_en && (w_period != '0);
  // >= rather than == so shrinking the period mid-count wraps at once instead of running away
  assign w_tone_wrap = (r_tone_cnt >= (w_period - PER_W'(1)));
  assign w_pwm_on    = (r_pwm_cnt < r_vol);

  assign w_timer_run = r_en && (r_remaining != '0);
  assign w_tick      = w_timer_run && (r_tick_cnt == TICK_LAST);
  assign w_expire    = w_tick && (r_remaining == PWM_BITS'(1));

  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      if (w_aw_beat) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= AWADDR;
      end
      if (w_w_beat) begin
        r_w_held <= 1'b1;
        r_wdata  <= WDATA;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_mapped ? 2'b00 : 2'b10;
      end else if (r_bvalid && BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // A CTRL write landing on the expiry edge takes priority over the auto-stop.
  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      r_en        <= 1'b0;
      r_mute      <= 1'b0;
      r_per_lo    <= '0;
      r_per_hi    <= '0;
      r_vol       <= '0;
      r_remaining <= '0;
      r_tick_cnt  <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= r_wdata[0];
        r_mute <= r_wdata[1];
      end else if (w_expire) begin
        r_en <= 1'b0;
      end
      if (w_wr_per_lo) r_per_lo <= r_wdata;
      if (w_wr_per_hi) r_per_hi <= r_wdata;
      if (w_wr_vol)    r_vol    <= r_wdata;
      if (w_wr_dur) begin
        r_remaining <= r_wdata;
        r_tick_cnt  <= '0;
      end else if (w_timer_run) begin
        if (w_tick) begin
          r_tick_cnt  <= '0;
          r_remaining <= r_remaining - PWM_BITS'(1);
        end else begin
          r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      r_tone_cnt <= '0;
      r_sq       <= 1'b0;
      r_pwm_cnt  <= '0;
      r_aud_sig  <= 1'b0;
    end else begin
      if (!w_tone_run) begin
        r_tone_cnt <= '0;
        r_sq       <= 1'b0;
      end else if (w_tone_wrap) begin
        r_tone_cnt <= '0;
        r_sq       <= !r_sq;
      end else begin
        r_tone_cnt <= r_tone_cnt + PER_W'(1);
      end
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_aud_sig <= r_en && !r_mute && r_sq && w_pwm_on;
    end
  end

endmodule
